// File: rtl/micro_uart_loader_if.sv
// rtl/micro_uart_loader_if.sv - UART RX byte stream in, IRAM write port out
interface micro_uart_loader_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 8
) ();
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [ADDR_BITS-1:0] iram_wa;
  logic                 iram_wen;
  logic [WIDTH-1:0]     iram_din;

  modport master (output rx_data, rx_valid, input iram_wa, iram_wen, iram_din);
  modport slave  (input rx_data, rx_valid, output iram_wa, iram_wen, iram_din);
endinterface

// File: rtl/micro_uart_loader.sv
// rtl/micro_uart_loader.sv - framed program loader: UART bytes -> IRAM words, gates micro reset
module micro_uart_loader #(
  parameter int WIDTH          = 16,
  parameter int IRAM_ADDR_BITS = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  micro_uart_loader_if.slave        bus,
  output logic                      cpu_reset_o,
  output logic                      loading_o,
  output logic                      load_done_o,
  output logic                      load_err_o,
  output logic [IRAM_ADDR_BITS:0]   words_loaded_o
);

  localparam logic [7:0] SYNC      = 8'hA5;
  localparam int         CW        = IRAM_ADDR_BITS + 1;
  // LEN is a single byte, so the largest frame is 255 words even for deep IRAMs
  localparam int         MAX_N_INT = (IRAM_ADDR_BITS >= 8) ? 255 : (1 << IRAM_ADDR_BITS);
  localparam logic [8:0] MAX_N     = 9'(MAX_N_INT);
  localparam int         TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA_HI, S_DATA_LO, S_CSUM} state_e;

  state_e                    state_q;
  logic [IRAM_ADDR_BITS-1:0] wa_q;
  logic                      wen_q;
  logic [WIDTH-1:0]          din_q;
  logic                      cpu_reset_q;
  logic                      load_done_q;
  logic                      load_err_q;
  logic [CW-1:0]             words_loaded_q;
  logic [CW-1:0]             len_q;
  logic [7:0]                hi_q;
  logic [7:0]                csum_q;
  logic [TW-1:0]             tmo_q;

  logic                      len_bad_d;
  logic [CW-1:0]             wcnt_d;

  assign len_bad_d = (bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > MAX_N);
  assign wcnt_d    = words_loaded_q + 1'b1;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= S_IDLE;
      wa_q           <= '0;
      wen_q          <= 1'b0;
      din_q          <= '0;
      cpu_reset_q    <= 1'b1;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
      words_loaded_q <= '0;
      len_q          <= '0;
      hi_q           <= '0;
      csum_q         <= '0;
      tmo_q          <= '0;
    end else begin
      wen_q <= 1'b0;
      if (bus.rx_valid) begin
        // An arriving byte always beats a timeout expiring in the same cycle
        tmo_q <= '0;
        unique case (state_q)
          S_IDLE: begin
            if (bus.rx_data == SYNC) begin
              state_q        <= S_LEN;
              cpu_reset_q    <= 1'b1;
              load_done_q    <= 1'b0;
              load_err_q     <= 1'b0;
              words_loaded_q <= '0;
              csum_q         <= '0;
            end
          end
          S_LEN: begin
            if (len_bad_d) begin
              load_err_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              len_q   <= CW'(bus.rx_data);
              state_q <= S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            hi_q    <= bus.rx_data;
            csum_q  <= csum_q ^ bus.rx_data;
            state_q <= S_DATA_LO;
          end
          S_DATA_LO: begin
            csum_q         <= csum_q ^ bus.rx_data;
            wen_q          <= 1'b1;
            wa_q           <= words_loaded_q[IRAM_ADDR_BITS-1:0];
            din_q          <= {hi_q, bus.rx_data};
            words_loaded_q <= wcnt_d;
            state_q        <= (wcnt_d == len_q) ? S_CSUM : S_DATA_HI;
          end
          S_CSUM: begin
            if (bus.rx_data == csum_q) begin
              load_done_q <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              load_err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        if (tmo_q == TMO_LAST) begin
          state_q     <= S_IDLE;
          load_err_q  <= 1'b1;
          cpu_reset_q <= 1'b1;
          tmo_q       <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign bus.iram_wa    = wa_q;
  assign bus.iram_wen   = wen_q;
  assign bus.iram_din   = din_q;
  assign cpu_reset_o    = cpu_reset_q;
  assign loading_o      = (state_q != S_IDLE);
  assign load_done_o    = load_done_q;
  assign load_err_o     = load_err_q;
  assign words_loaded_o = words_loaded_q;

endmodule

// File: tb/tb_micro_uart_loader.sv
// tb/tb_micro_uart_loader.sv - scoreboard bench for micro_uart_loader
module tb_micro_uart_loader;
  localparam int AB  = 4;
  localparam int W   = 16;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_reset, loading, load_done, load_err;
  logic [AB:0]   words_loaded;

  micro_uart_loader_if #(.WIDTH(W), .ADDR_BITS(AB)) bus ();

  micro_uart_loader #(.WIDTH(W), .IRAM_ADDR_BITS(AB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i          (clk),
    .reset_ni       (rst_n),
    .bus            (bus),
    .cpu_reset_o    (cpu_reset),
    .loading_o      (loading),
    .load_done_o    (load_done),
    .load_err_o     (load_err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AB+W-1:0] exp_q[$];
  logic [7:0]      frame_q[$];
  logic [AB+W-1:0] mon_e;

  logic m_cpu_reset = 1'b1;
  logic m_done      = 1'b0;
  logic m_err       = 1'b0;
  logic m_loading   = 1'b0;
  int   m_words     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every IRAM write must match the next expected word
  always @(negedge clk) begin
    if (bus.iram_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: wa=0x%0h din=0x%0h, expected no write", bus.iram_wa, bus.iram_din);
      end else begin
        mon_e = exp_q.pop_front();
        chk("iram_write{wa,din}", 32'({bus.iram_wa, bus.iram_din}), 32'(mon_e));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  task automatic check_state(input string tag);
    chk({tag, ".cpu_reset"},    32'(cpu_reset),    32'(m_cpu_reset));
    chk({tag, ".loading"},      32'(loading),      32'(m_loading));
    chk({tag, ".load_done"},    32'(load_done),    32'(m_done));
    chk({tag, ".load_err"},     32'(load_err),     32'(m_err));
    chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(m_words));
  endtask

  task automatic model_reset();
    m_cpu_reset = 1'b1;
    m_done      = 1'b0;
    m_err       = 1'b0;
    m_loading   = 1'b0;
    m_words     = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".iram_wa"},  32'(bus.iram_wa),  32'd0);
    chk({tag, ".iram_wen"}, 32'(bus.iram_wen), 32'd0);
    chk({tag, ".iram_din"}, 32'(bus.iram_din), 32'd0);
    check_state(tag);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits `gap` idle cycles, then presents one byte for exactly one edge
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) cycle();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    cycle();
    bus.rx_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int fixed);
    return (fixed < 0) ? int'($urandom_range(0, 3)) : fixed;
  endfunction

  // Sends frame_q (optional garbage prefix, then one frame) and predicts its outcome
  task automatic do_frame(input int gap_fix);
    int         s;
    int         n;
    logic [7:0] x;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] cs;
    s = 0;
    while (s < frame_q.size() && frame_q[s] != 8'hA5) begin
      send(frame_q[s], pick_gap(gap_fix));
      s++;
    end
    if (s > 0) check_state("garbage");
    if (s + 1 < frame_q.size()) begin
      send(8'hA5, pick_gap(gap_fix));
      m_cpu_reset = 1'b1;
      m_done      = 1'b0;
      m_err       = 1'b0;
      m_words     = 0;
      m_loading   = 1'b1;
      check_state("sync");
      n = int'(frame_q[s+1]);
      send(frame_q[s+1], pick_gap(gap_fix));
      if (n == 0 || n > (1 << AB)) begin
        m_err     = 1'b1;
        m_loading = 1'b0;
        check_state("len_err");
      end else begin
        check_state("len_ok");
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
          hi = frame_q[s+2+2*i];
          lo = frame_q[s+3+2*i];
          x  = x ^ hi ^ lo;
          exp_q.push_back({AB'(i), hi, lo});
        end
        for (int i = 0; i < 2 * n; i++) send(frame_q[s+2+i], pick_gap(gap_fix));
        cs = frame_q[s+2+2*n];
        send(cs, pick_gap(gap_fix));
        m_words   = n;
        m_loading = 1'b0;
        if (cs == x) begin
          m_done      = 1'b1;
          m_cpu_reset = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        check_state("frame_end");
      end
    end
    repeat (3) cycle();
  endtask

  task automatic build_random(input bit len_bad);
    int         n;
    int         ng;
    logic [7:0] b;
    logic [7:0] x;
    frame_q.delete();
    ng = int'($urandom_range(0, 3));
    repeat (ng) begin
      do b = 8'($urandom); while (b == 8'hA5);
      frame_q.push_back(b);
    end
    frame_q.push_back(8'hA5);
    if (len_bad) begin
      n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 255));
      frame_q.push_back(8'(n));
    end else begin
      n = int'($urandom_range(1, 16));
      frame_q.push_back(8'(n));
      x = 8'h00;
      repeat (2 * n) begin
        b = 8'($urandom);
        x = x ^ b;
        frame_q.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
      frame_q.push_back(x);
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) cycle();
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (2) cycle();
    check_reset_outputs("after_reset");

    frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hC0, 8'h00, 8'hE6};
    do_frame(-1);
    chk("good.last_wa", 32'(bus.iram_wa), 32'd1);
    chk("good.last_din", 32'(bus.iram_din), 32'hC000);

    frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hC0, 8'h00, 8'hE7};
    do_frame(-1);

    frame_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h12, 8'h34, 8'hC0, 8'h00, 8'hE6};
    do_frame(-1);

    frame_q = '{8'hA5, 8'h00};
    do_frame(-1);
    frame_q = '{8'hA5, 8'h11};
    do_frame(-1);

    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h10);
    begin
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      repeat (32) begin
        b = 8'($urandom);
        x = x ^ b;
        frame_q.push_back(b);
      end
      frame_q.push_back(x);
    end
    do_frame(-1);

    for (int k = 0; k < 24; k++) begin
      build_random($urandom_range(0, 5) == 0);
      do_frame(-1);
    end

    // Silence after the high byte: abort exactly TMO cycles after its strobe
    send(8'hA5, 0);
    model_reset();
    m_loading = 1'b1;
    send(8'h01, 2);
    send(8'h12, 2);
    repeat (TMO - 1) cycle();
    check_state("pre_timeout");
    cycle();
    m_err     = 1'b1;
    m_loading = 1'b0;
    check_state("timeout");
    repeat (3) cycle();

    // Every byte lands on the would-be expiry cycle
    frame_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h26};
    do_frame(TMO - 1);

    send(8'hA5, 0);
    send(8'h01, 1);
    send(8'h12, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midframe_reset");
    repeat (3) cycle();
    rst_n = 1'b1;
    send(8'h34, 0);
    repeat (2) cycle();
    check_reset_outputs("post_reset");

    build_random(1'b0);
    do_frame(-1);

    repeat (5) cycle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/micro_uart_loader.md
Name: micro_uart_loader

Overview:
Upstream program-load stage for the 16-bit micro core. Consumes a byte stream from the UART receiver, validates a framed program image, and writes it word-by-word into the micro's instruction RAM through the IRAM write port (iram_wa/iram_wen/iram_din). Holds the core in reset while loading and releases it only after a frame with a correct checksum, so the core always starts from PC 0 on a complete program.

Parameters:
WIDTH, 16, instruction word width (fixed at 16; two bytes per word)
IRAM_ADDR_BITS, 8, IRAM address width; maximum program length is 2^IRAM_ADDR_BITS words, capped at 255
TIMEOUT_CYCLES, 1_000_000, idle clock cycles allowed between bytes inside a frame before abort

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-low reset
rx_data  in  8  received byte from the UART RX
rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
iram_wa  out  IRAM_ADDR_BITS  IRAM write address
iram_wen  out  1  IRAM write enable, one-cycle pulse per word
iram_din  out  WIDTH  IRAM write data
cpu_reset  out  1  active-high reset to the micro
loading  out  1  high while a frame is in progress (any state other than IDLE)
load_done  out  1  sticky: last frame loaded successfully
load_err  out  1  sticky: last frame aborted (bad length, bad checksum, or timeout)
words_loaded  out  IRAM_ADDR_BITS+1  number of words written by the current or last frame

Behaviour:
- Frame format: SYNC 0xA5, LEN (word count N), 2N data bytes (high byte first), CSUM = XOR of all 2N data bytes.
- Reset (reset low, asynchronous): state IDLE; iram_wa=0, iram_wen=0, iram_din=0, cpu_reset=1, loading=0, load_done=0, load_err=0, words_loaded=0, timeout counter=0.
- FSM states: IDLE, LEN, DATA_HI, DATA_LO, CSUM. All transitions are taken only on rx_valid except timeout.
- IDLE: a byte other than 0xA5 is ignored and leaves all outputs unchanged. On 0xA5: go to LEN, cpu_reset=1, clear load_done, load_err and words_loaded, and zero the running XOR and the word index.
- LEN: if N==0 or N>2^IRAM_ADDR_BITS, set load_err and go to IDLE. Otherwise latch N and go to DATA_HI.
- DATA_HI: latch the byte as the high half, XOR it into the checksum, and go to DATA_LO.
- DATA_LO: XOR the byte into the checksum. On the next cycle, iram_wen=1 for exactly one cycle, with iram_wa = word index and iram_din = {hi, lo}. Increment the word index and words_loaded. If the index equals N, go to CSUM; otherwise go to DATA_HI.
- iram_wa and iram_din hold their last values when iram_wen=0. The write latency is one cycle after the DATA_LO strobe.
- CSUM: if the byte equals the running XOR, set load_done, and cpu_reset falls one cycle after the strobe. If it does not match, set load_err and keep cpu_reset=1. In both cases go to IDLE.
- Timeout: the counter clears on every rx_valid and counts in every state except IDLE. When it reaches TIMEOUT_CYCLES-1 without a byte, go to IDLE, set load_err and keep cpu_reset=1. If rx_valid arrives in the same cycle as expiry, the byte wins and no timeout occurs.
- Re-load: a SYNC byte received while the core is running (after load_done) immediately reasserts cpu_reset. IRAM contents beyond the new N are not cleared.
- Partially written IRAM after an abort is not rolled back. cpu_reset stays high, so the core never executes a partial image.
- Reset asserted mid-frame aborts the frame with no further writes. After release, all outputs hold their reset values.

Test Plan:
- Good frame: bytes A5 02 12 34 C0 00 E6 -> iram_wen pulses at wa=0 din=0x1234 and at wa=1 din=0xC000; words_loaded=2; load_done=1; cpu_reset=0 one cycle after the E6 strobe.
- Bad checksum: A5 02 12 34 C0 00 E7 -> both writes occur; load_err=1, load_done=0, cpu_reset stays 1.
- Garbage before sync: 00 FF 5A, then the good frame -> no writes and no flag changes during the garbage; the result matches the good-frame case.
- Length errors: A5 00 -> load_err=1 with no writes. With IRAM_ADDR_BITS=4, A5 11 -> load_err=1 with no writes.
- Timeout (TIMEOUT_CYCLES=50): A5 01 12, then silence -> load_err=1 exactly 50 cycles after the 12 strobe; state returns to IDLE; no iram_wen. Also drive a byte on the expiry cycle and check that no abort occurs.
- Reload and reset mid-frame: after a good load, send A5 -> cpu_reset=1 on the next cycle and load_done=0. Pull reset low after A5 01 12 -> all outputs return to reset values and no write occurs.
